// File: rtl/tt_um_jasonk_6502.sv
// Reduced 6502-style core behind a three-clock multiplexed TinyTapeout bus.
// Each memory access drives address low, then address high, then the data phase.
// After the bus cycles of an instruction, one internal EXEC clock updates the registers.
module tt_um_jasonk_6502 #(
    parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
    input  logic       clk,
    input  logic       rst_n,     // active-high synchronous reset; the name comes from the harness
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        VEC_LO, VEC_HI, FETCH, OPR1, OPR2, DATA, EXEC
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  phase, phase_nx;
    logic [15:0] pc;
    logic [7:0]  a_reg, x_reg, y_reg;
    logic        flag_n, flag_v, flag_z, flag_c;
    logic [7:0]  ir, op_lo, op_hi, dbuf;

    logic [15:0] bus_addr;
    logic        rw, sync;

    // exec-stage decode results
    logic [7:0]  res;
    logic        wr_a, wr_x, wr_y, set_nz, set_c, c_nx, set_v, v_nx, ld_pc;
    logic [15:0] pc_nx;
    logic [7:0]  m_val, addend;
    logic        cin;
    logic [8:0]  sum9;

    logic unused_in;
    assign unused_in = ena ^ (^uio_in);

    // Opcodes that carry at least one operand byte.
    function automatic logic has_opr1(input logic [7:0] op);
        case (op)
            8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49, 8'hC9,
            8'hF0, 8'hD0, 8'hB0, 8'h90, 8'h4C, 8'hAD, 8'h8D: has_opr1 = 1'b1;
            default:                                          has_opr1 = 1'b0;
        endcase
    endfunction

    // Opcodes that use an absolute address: two operand bytes.
    function automatic logic has_opr2(input logic [7:0] op);
        has_opr2 = (op == 8'h4C) || (op == 8'hAD) || (op == 8'h8D);
    endfunction

    // Opcodes that make a data access at the absolute address.
    function automatic logic has_data(input logic [7:0] op);
        has_data = (op == 8'hAD) || (op == 8'h8D);
    endfunction

    // State register: reset restarts at the vector fetch, which aborts any pending write.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= VEC_LO;
            phase <= 2'd0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
        end
    end

    // Next-state logic: a bus state advances through phases 0-2; EXEC always returns to FETCH.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        if (state == EXEC) begin
            state_nx = FETCH;
            phase_nx = 2'd0;
        end else if (phase != 2'd2) begin
            phase_nx = phase + 2'd1;
        end else begin
            phase_nx = 2'd0;
            case (state)
                VEC_LO:  state_nx = VEC_HI;
                VEC_HI:  state_nx = FETCH;
                FETCH:   state_nx = has_opr1(ui_in) ? OPR1 : EXEC;
                OPR1:    state_nx = has_opr2(ir) ? OPR2 : EXEC;
                OPR2:    state_nx = has_data(ir) ? DATA : EXEC;
                DATA:    state_nx = EXEC;
                default: state_nx = VEC_LO;
            endcase
            if (state_nx == EXEC) phase_nx = 2'd3;
        end
    end

    // Bus outputs are decoded from registered state only.
    always_comb begin
        case (state)
            VEC_LO:  bus_addr = RESET_VEC;
            VEC_HI:  bus_addr = RESET_VEC + 16'd1;
            DATA:    bus_addr = {op_hi, op_lo};
            default: bus_addr = pc;
        endcase
        rw   = !(state == DATA && ir == 8'h8D);
        sync = (state == FETCH);
        case (phase)
            2'd0:    uo_out = bus_addr[7:0];
            2'd1:    uo_out = bus_addr[15:8];
            2'd2:    uo_out = rw ? 8'h00 : a_reg;
            default: uo_out = 8'h00;
        endcase
        uio_out = {4'b0000, sync, rw, phase};
        uio_oe  = 8'h0F;
    end

    // EXEC decode: the ALU result and which registers and flags it commits.
    always_comb begin
        res    = 8'h00;
        wr_a   = 1'b0;
        wr_x   = 1'b0;
        wr_y   = 1'b0;
        set_nz = 1'b0;
        set_c  = 1'b0;
        c_nx   = 1'b0;
        set_v  = 1'b0;
        ld_pc  = 1'b0;
        pc_nx  = pc + {{8{op_lo[7]}}, op_lo};
        m_val  = (ir == 8'hAD) ? dbuf : op_lo;
        // SBC and CMP add the complemented operand; CMP forces carry-in so it is a true A-M.
        addend = (ir == 8'hE9 || ir == 8'hC9) ? ~m_val : m_val;
        cin    = (ir == 8'hC9) ? 1'b1 : flag_c;
        sum9   = {1'b0, a_reg} + {1'b0, addend} + {8'b0, cin};
        v_nx   = (a_reg[7] == addend[7]) && (sum9[7] != a_reg[7]);
        case (ir)
            8'hA9, 8'hAD: begin res = m_val; wr_a = 1'b1; set_nz = 1'b1; end
            8'hA2: begin res = op_lo; wr_x = 1'b1; set_nz = 1'b1; end
            8'hA0: begin res = op_lo; wr_y = 1'b1; set_nz = 1'b1; end
            8'h69, 8'hE9: begin
                res = sum9[7:0]; wr_a = 1'b1; set_nz = 1'b1;
                set_c = 1'b1; c_nx = sum9[8]; set_v = 1'b1;
            end
            8'h29: begin res = a_reg & op_lo; wr_a = 1'b1; set_nz = 1'b1; end
            8'h09: begin res = a_reg | op_lo; wr_a = 1'b1; set_nz = 1'b1; end
            8'h49: begin res = a_reg ^ op_lo; wr_a = 1'b1; set_nz = 1'b1; end
            8'hC9: begin res = sum9[7:0]; set_nz = 1'b1; set_c = 1'b1; c_nx = sum9[8]; end
            8'hE8: begin res = x_reg + 8'd1; wr_x = 1'b1; set_nz = 1'b1; end
            8'hCA: begin res = x_reg - 8'd1; wr_x = 1'b1; set_nz = 1'b1; end
            8'hC8: begin res = y_reg + 8'd1; wr_y = 1'b1; set_nz = 1'b1; end
            8'h88: begin res = y_reg - 8'd1; wr_y = 1'b1; set_nz = 1'b1; end
            8'hAA: begin res = a_reg; wr_x = 1'b1; set_nz = 1'b1; end
            8'h8A: begin res = x_reg; wr_a = 1'b1; set_nz = 1'b1; end
            8'hA8: begin res = a_reg; wr_y = 1'b1; set_nz = 1'b1; end
            8'h98: begin res = y_reg; wr_a = 1'b1; set_nz = 1'b1; end
            8'h18: begin set_c = 1'b1; c_nx = 1'b0; end
            8'h38: begin set_c = 1'b1; c_nx = 1'b1; end
            8'h4C: begin ld_pc = 1'b1; pc_nx = {op_hi, op_lo}; end
            8'hF0: ld_pc = flag_z;
            8'hD0: ld_pc = !flag_z;
            8'hB0: ld_pc = flag_c;
            8'h90: ld_pc = !flag_c;
            default: ;
        endcase
    end

    // Datapath: bus read data is captured at the end of phase 2; registers commit in EXEC.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc     <= 16'h0000;
            a_reg  <= 8'h00;
            x_reg  <= 8'h00;
            y_reg  <= 8'h00;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            ir     <= 8'h00;
            op_lo  <= 8'h00;
            op_hi  <= 8'h00;
            dbuf   <= 8'h00;
        end else begin
            if (phase == 2'd2) begin
                case (state)
                    VEC_LO: pc[7:0]  <= ui_in;
                    VEC_HI: pc[15:8] <= ui_in;
                    FETCH:  begin ir    <= ui_in; pc <= pc + 16'd1; end
                    OPR1:   begin op_lo <= ui_in; pc <= pc + 16'd1; end
                    OPR2:   begin op_hi <= ui_in; pc <= pc + 16'd1; end
                    DATA:   if (rw) dbuf <= ui_in;
                    default: ;
                endcase
            end
            if (state == EXEC) begin
                if (wr_a)   a_reg  <= res;
                if (wr_x)   x_reg  <= res;
                if (wr_y)   y_reg  <= res;
                if (set_nz) begin flag_n <= res[7]; flag_z <= (res == 8'h00); end
                if (set_c)  flag_c <= c_nx;
                if (set_v)  flag_v <= v_nx;
                if (ld_pc)  pc     <= pc_nx;
            end
        end
    end

endmodule

// File: tb/tb_tt_um_jasonk_6502.sv
// Directed bench: a 64 KiB memory model answers the multiplexed bus; each task is one scenario.
module tb_tt_um_jasonk_6502;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    tt_um_jasonk_6502 dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  bus_lo = 8'h00;
    logic [7:0]  bus_hi = 8'h00;
    int          wr_cnt = 0;
    logic [15:0] wr_addr = 16'h0000;
    logic [7:0]  wr_data = 8'h00;

    // Answer the bus as it appears at this falling edge.
    task automatic bus();
        case (uio_out[1:0])
            2'd0: bus_lo = uo_out;
            2'd1: bus_hi = uo_out;
            2'd2: begin
                if (uio_out[2]) ui_in = mem[{bus_hi, bus_lo}];
                else begin
                    wr_cnt++;
                    wr_addr = {bus_hi, bus_lo};
                    wr_data = uo_out;
                    mem[{bus_hi, bus_lo}] = uo_out;
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        bus();
        @(negedge clk);
    endtask

    // Advance to phase 1 of the next opcode fetch; clks counts clocks since the call.
    task automatic wait_fetch(output int clks, output logic [15:0] addr);
        clks = 0;
        do begin
            tick();
            clks++;
        end while (!(uio_out[3] && uio_out[1:0] == 2'd1) && clks < 40);
        addr = {uo_out, bus_lo};
        if (!(uio_out[3] && uio_out[1:0] == 2'd1)) begin
            checks++; errors++;
            $display("FAIL fetch_timeout: no opcode fetch within %0d clocks", clks);
        end
    endtask

    task automatic load(input logic [15:0] base, input int n, input logic [127:0] bytes);
        for (int i = 0; i < n; i++) mem[base + 16'(i)] = bytes[8*(n-1-i) +: 8];
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        wr_cnt = 0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_uo  [6] = '{8'hFC, 8'hFF, 8'h00, 8'hFD, 8'hFF, 8'h00};
        logic [7:0] exp_uio [6] = '{8'h04, 8'h05, 8'h06, 8'h04, 8'h05, 8'h06};
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (uo_out !== 8'hFC) begin errors++; $display("FAIL reset_uo got=%h exp=fc", uo_out); end
        checks++; if (uio_out !== 8'h04) begin errors++; $display("FAIL reset_uio got=%h exp=04", uio_out); end
        checks++; if (uio_oe !== 8'h0F) begin errors++; $display("FAIL reset_oe got=%h exp=0f", uio_oe); end
        checks++; if (dut.a_reg !== 8'h00 || dut.pc !== 16'h0000) begin
            errors++; $display("FAIL reset_regs got a=%h pc=%h exp 00/0000", dut.a_reg, dut.pc);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (uo_out !== exp_uo[i] || uio_out !== exp_uio[i]) begin
                errors++;
                $display("FAIL vector_clk%0d got=%h/%h exp=%h/%h", i, uo_out, uio_out, exp_uo[i], exp_uio[i]);
            end
            tick();
        end
        checks++; if (uo_out !== 8'h00 || uio_out !== 8'h0C) begin
            errors++; $display("FAIL first_fetch_lo got=%h/%h exp=00/0c", uo_out, uio_out);
        end
        tick();
        checks++; if (uo_out !== 8'h80 || uio_out !== 8'h0D) begin
            errors++; $display("FAIL first_fetch_hi got=%h/%h exp=80/0d", uo_out, uio_out);
        end
    endtask

    task automatic test_alu_overflow();
        logic [15:0] ea [5] = '{16'h8000, 16'h8002, 16'h8003, 16'h8005, 16'h8008};
        int          el [5] = '{7, 7, 4, 7, 13};
        int          c;
        logic [15:0] ad;
        load(16'h8000, 9, 128'hA97F1869018D0002EA);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wait_fetch(c, ad);
            checks++; if (ad !== ea[i] || c != el[i]) begin
                errors++; $display("FAIL alu_step%0d got=%h/%0d exp=%h/%0d", i, ad, c, ea[i], el[i]);
            end
        end
        checks++; if (wr_cnt != 1 || wr_addr !== 16'h0200 || wr_data !== 8'h80) begin
            errors++; $display("FAIL sta_write got=%0d %h %h exp=1 0200 80", wr_cnt, wr_addr, wr_data);
        end
        checks++; if ({dut.flag_n, dut.flag_v, dut.flag_z, dut.flag_c} !== 4'b1100) begin
            errors++; $display("FAIL adc_flags got=%b exp=1100",
                               {dut.flag_n, dut.flag_v, dut.flag_z, dut.flag_c});
        end
    endtask

    task automatic test_loop();
        logic [15:0] ea [6] = '{16'h8000, 16'h8002, 16'h8003, 16'h8002, 16'h8003, 16'h8005};
        int          el [6] = '{7, 7, 4, 7, 4, 7};
        int          c;
        logic [15:0] ad;
        load(16'h8000, 7, 128'hA202CAD0FDEAEA);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wait_fetch(c, ad);
            checks++; if (ad !== ea[i] || c != el[i]) begin
                errors++; $display("FAIL loop_step%0d got=%h/%0d exp=%h/%0d", i, ad, c, ea[i], el[i]);
            end
        end
        checks++; if (dut.x_reg !== 8'h00 || dut.flag_z !== 1'b1) begin
            errors++; $display("FAIL loop_end got x=%h z=%b exp x=00 z=1", dut.x_reg, dut.flag_z);
        end
    endtask

    task automatic test_cmp_sbc();
        int          c;
        logic [15:0] ad;
        load(16'h8000, 8, 128'hA910C91038E920EA);
        do_reset();
        wait_fetch(c, ad);
        wait_fetch(c, ad);
        wait_fetch(c, ad);
        checks++; if (ad !== 16'h8004 || dut.flag_z !== 1'b1 || dut.flag_c !== 1'b1 || dut.a_reg !== 8'h10) begin
            errors++; $display("FAIL cmp got pc=%h z=%b c=%b a=%h exp 8004 1 1 10",
                               ad, dut.flag_z, dut.flag_c, dut.a_reg);
        end
        wait_fetch(c, ad);
        wait_fetch(c, ad);
        checks++; if (ad !== 16'h8007 || dut.a_reg !== 8'hF0 || dut.flag_c !== 1'b0
                      || dut.flag_n !== 1'b1 || dut.flag_v !== 1'b0) begin
            errors++; $display("FAIL sbc got pc=%h a=%h c=%b n=%b v=%b exp 8007 f0 0 1 0",
                               ad, dut.a_reg, dut.flag_c, dut.flag_n, dut.flag_v);
        end
    endtask

    task automatic test_jmp_unknown();
        int          c;
        logic [15:0] ad;
        load(16'h8000, 3, 128'h4C3412);
        mem[16'h1234] = 8'h02;
        mem[16'h1235] = 8'hEA;
        do_reset();
        wait_fetch(c, ad);
        wait_fetch(c, ad);
        checks++; if (ad !== 16'h1234 || c != 10) begin
            errors++; $display("FAIL jmp got=%h/%0d exp=1234/10", ad, c);
        end
        wait_fetch(c, ad);
        checks++; if (ad !== 16'h1235 || c != 4) begin
            errors++; $display("FAIL unknown_op got=%h/%0d exp=1235/4", ad, c);
        end
    endtask

    task automatic test_misc();
        logic [15:0] ea [10] = '{16'h8000, 16'h8002, 16'h8003, 16'h8004, 16'h8007,
                                 16'h8008, 16'h800A, 16'h800B, 16'h800F, 16'h8011};
        int          el [10] = '{7, 7, 4, 4, 13, 4, 7, 4, 7, 7};
        int          c;
        logic [15:0] ad;
        load(16'h8000, 9, 128'hA200CAE8AD1090AA49);
        load(16'h8009, 9, 128'hFF38B002EAEA9005EA);
        mem[16'h9010] = 8'hC3;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wait_fetch(c, ad);
            checks++; if (ad !== ea[i] || c != el[i]) begin
                errors++; $display("FAIL misc_step%0d got=%h/%0d exp=%h/%0d", i, ad, c, ea[i], el[i]);
            end
            case (i)
                2: begin checks++; if (dut.x_reg !== 8'hFF || dut.flag_n !== 1'b1) begin
                       errors++; $display("FAIL dex_wrap got x=%h n=%b exp ff 1", dut.x_reg, dut.flag_n); end end
                3: begin checks++; if (dut.x_reg !== 8'h00 || dut.flag_z !== 1'b1) begin
                       errors++; $display("FAIL inx_wrap got x=%h z=%b exp 00 1", dut.x_reg, dut.flag_z); end end
                4: begin checks++; if (dut.a_reg !== 8'hC3) begin
                       errors++; $display("FAIL lda_abs got=%h exp=c3", dut.a_reg); end end
                5: begin checks++; if (dut.x_reg !== 8'hC3) begin
                       errors++; $display("FAIL tax got=%h exp=c3", dut.x_reg); end end
                6: begin checks++; if (dut.a_reg !== 8'h3C || dut.flag_n !== 1'b0) begin
                       errors++; $display("FAIL eor got a=%h n=%b exp 3c 0", dut.a_reg, dut.flag_n); end end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid_sta();
        int          c;
        int          n;
        logic [15:0] ad;
        load(16'h8000, 6, 128'hA9558D0003EA);
        mem[16'h0300] = 8'h00;
        do_reset();
        wait_fetch(c, ad);
        wait_fetch(c, ad);
        n = 0;
        while (!(uio_out[1:0] == 2'd1 && uio_out[2] == 1'b0) && n < 40) begin
            tick();
            n++;
        end
        checks++; if (!(uio_out[1:0] == 2'd1 && uio_out[2] == 1'b0)) begin
            errors++; $display("FAIL sta_phase1 got uio=%h exp phase1 write", uio_out);
        end
        rst_n = 1'b1;
        tick();
        checks++; if (uo_out !== 8'hFC || uio_out !== 8'h04) begin
            errors++; $display("FAIL mid_reset_out got=%h/%h exp=fc/04", uo_out, uio_out);
        end
        tick();
        tick();
        rst_n = 1'b0;
        wait_fetch(c, ad);
        checks++; if (ad !== 16'h8000 || c != 7) begin
            errors++; $display("FAIL restart got=%h/%0d exp=8000/7", ad, c);
        end
        checks++; if (wr_cnt != 0 || mem[16'h0300] !== 8'h00) begin
            errors++; $display("FAIL aborted_write got=%0d/%h exp=0/00", wr_cnt, mem[16'h0300]);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
        test_reset();
        test_alu_overflow();
        test_loop();
        test_cmp_sbc();
        test_jmp_unknown();
        test_misc();
        test_reset_mid_sta();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
